wb_stage: RTL
=============

# wb_stage

Writeback stage of the Cardinal CMP core pipeline. It sits directly upstream of the register file and drives its write port (wrEn, rD, ppp, d_in). It holds the MEM/WB pipeline register. For loads it waits on the variable-latency data-memory/NIC response, stalling the pipeline until the data returns. It also keeps a retired-instruction counter.

## Interface
- CNT_W, 32, width of the retired-instruction counter
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- mem_valid  in  1  MEM stage presents an instruction this cycle
- mem_wr_en  in  1  instruction writes a GPR
- mem_rd  in  [0:4]  destination register
- mem_ppp  in  [0:2]  participation field (000 full, 001 upper word [0:31], 010 lower word [32:63], 011 even bytes, 100 odd bytes; 101-111 reserved)
- mem_is_load  in  1  result comes from data memory, not ALU
- mem_alu_res  in  [0:63]  ALU result
- dmem_valid  in  1  load response valid
- dmem_data  in  [0:63]  load response data
- wb_stall  out  1  upstream must hold; mem_valid is ignored while high
- rf_wr_en  out  1  to RF wrEn
- rf_rd  out  [0:4]  to RF rD
- rf_ppp  out  [0:2]  to RF ppp
- rf_data  out  [0:63]  to RF d_in
- retired  out  [0:CNT_W-1]  count of completed instructions
- err_unexp_rsp  out  1  sticky: dmem_valid seen with no load outstanding

## Operation
- FSM states IDLE, WAIT_LD. Reset -> IDLE. All outputs 0 at reset.
- IDLE, mem_valid=1, mem_is_load=0: capture fields; next cycle rf_wr_en=mem_wr_en, rf_rd, rf_ppp, rf_data=mem_alu_res; stay IDLE.
- IDLE, mem_valid=1, mem_is_load=1: latch rd/ppp/wr_en; go to WAIT_LD; rf_wr_en=0.
- WAIT_LD, dmem_valid=0: hold state; rf_wr_en=0.
- WAIT_LD, dmem_valid=1: next cycle rf_wr_en=latched wr_en, rf_data=dmem_data, latched rd/ppp; go to IDLE.
- wb_stall = (state==WAIT_LD), registered. No combinational path from dmem_valid.
- rf_wr_en is forced 0 when rd==0 or ppp is reserved (101-111). The instruction still counts as retired.
- rf_wr_en/rf_rd/rf_ppp/rf_data are valid for exactly one cycle per instruction. rf_wr_en deasserts in bubble cycles. rf_data holds its last value when not written (don't-care).
- retired increments by 1 in the cycle an instruction's RF commit is presented. This includes non-writing instructions (mem_wr_en=0). It wraps modulo 2^CNT_W.
- dmem_valid in IDLE is ignored for data and sets err_unexp_rsp. err_unexp_rsp clears only on reset.
- The RF's same-cycle bypass (rD==rA) relies on rf_* being registered outputs. This block must not add further delay.

## Timing
- Non-load: accepted at edge N; rf_* visible during cycle N+1 (1-cycle latency); back-to-back throughput is 1/cycle.
- Load: accepted at edge N; wb_stall high from cycle N+1. dmem_valid is sampled at edge M>N. rf_* are visible and wb_stall is low in cycle M+1, so the earliest next accept is edge M+1.
- dmem_valid at the edge immediately after accept (M=N+1) is legal, giving a 2-cycle load latency.
- Reset mid-WAIT_LD: the pending load is dropped with no RF write, and retired is cleared.
- mem_valid while wb_stall=1: ignored; upstream is responsible for holding it.

## Structure
- The shared package cardinal_pkg holds the PPP code constants (PPP_FULL=000, PPP_UPPER=001, PPP_LOWER=010, PPP_EVEN=011, PPP_ODD=100), the 64-bit data width, the 5-bit register index width, and the FSM state encoding.
- Single module; no sub-module required.

## Test plan
- Reset, then ALU op rd=5, ppp=000, res=64'h0123_4567_89AB_CDEF -> one cycle later rf_wr_en=1, rf_rd=5, rf_data matches; retired=1.
- Load rd=7, ppp=001, dmem_valid 3 cycles later with data 64'hDEAD_BEEF_0000_0001 -> wb_stall high 3 cycles; then rf_wr_en=1, rf_rd=7, rf_ppp=001, rf_data matches, wb_stall=0.
- ALU op rd=0, then ALU op ppp=101 -> rf_wr_en=0 both; retired advances by 2.
- Back-to-back ALU ops on 4 consecutive cycles -> 4 consecutive rf_wr_en pulses with no bubble; load with dmem_valid on the first cycle after accept -> commit 2 cycles after accept.
- dmem_valid pulse in IDLE -> err_unexp_rsp=1 and stays set; no RF write.
- Reset asserted during WAIT_LD -> no rf_wr_en afterwards, wb_stall=0, retired=0, state IDLE.

Source files
------------

// File: rtl/cardinal_pkg.sv
// Shared Cardinal CMP core definitions: datapath widths, PPP codes, writeback FSM states.
package cardinal_pkg;

  localparam int unsigned DATA_W = 64;
  localparam int unsigned REG_W  = 5;
  localparam int unsigned PPP_W  = 3;

  localparam logic [PPP_W-1:0] PPP_FULL  = 3'b000;
  localparam logic [PPP_W-1:0] PPP_UPPER = 3'b001;
  localparam logic [PPP_W-1:0] PPP_LOWER = 3'b010;
  localparam logic [PPP_W-1:0] PPP_EVEN  = 3'b011;
  localparam logic [PPP_W-1:0] PPP_ODD   = 3'b100;

  typedef enum logic {
    WB_IDLE    = 1'b0,
    WB_WAIT_LD = 1'b1
  } wb_state_e;

  // A commit only writes the RF when it asks to, targets a real register
  // (r0 is not writable) and carries a defined participation code.
  function automatic logic rf_commit_ok(input logic             wr_en,
                                        input logic [REG_W-1:0] rd,
                                        input logic [PPP_W-1:0] ppp);
    return wr_en && (rd != '0) && (ppp <= PPP_ODD);
  endfunction

endpackage

// File: rtl/wb_stage.sv
// Writeback stage: MEM/WB register, load-response wait, RF write port, retire counter.
module wb_stage
  import cardinal_pkg::*;
#(
  parameter int unsigned CNT_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              mem_valid,
  input  logic              mem_wr_en,
  input  logic [0:4]        mem_rd,
  input  logic [0:2]        mem_ppp,
  input  logic              mem_is_load,
  input  logic [0:63]       mem_alu_res,
  input  logic              dmem_valid,
  input  logic [0:63]       dmem_data,
  output logic              wb_stall,
  output logic              rf_wr_en,
  output logic [0:4]        rf_rd,
  output logic [0:2]        rf_ppp,
  output logic [0:63]       rf_data,
  output logic [0:CNT_W-1]  retired,
  output logic              err_unexp_rsp
);

  wb_state_e              state_q, state_d;
  logic                   stall_q, stall_d;
  logic                   rf_wr_en_q, rf_wr_en_d;
  logic [REG_W-1:0]       rf_rd_q, rf_rd_d;
  logic [PPP_W-1:0]       rf_ppp_q, rf_ppp_d;
  logic [DATA_W-1:0]      rf_data_q, rf_data_d;
  logic                   pend_wr_en_q, pend_wr_en_d;
  logic [REG_W-1:0]       pend_rd_q, pend_rd_d;
  logic [PPP_W-1:0]       pend_ppp_q, pend_ppp_d;
  logic [CNT_W-1:0]       retired_q, retired_d;
  logic                   err_q, err_d;

  // Next-state: accept from MEM in IDLE, wait for the load response in WAIT_LD.
  always_comb begin
    state_d      = state_q;
    rf_wr_en_d   = 1'b0;
    rf_rd_d      = rf_rd_q;
    rf_ppp_d     = rf_ppp_q;
    rf_data_d    = rf_data_q;
    pend_wr_en_d = pend_wr_en_q;
    pend_rd_d    = pend_rd_q;
    pend_ppp_d   = pend_ppp_q;
    retired_d    = retired_q;
    err_d        = err_q;
    unique case (state_q)
      WB_IDLE: begin
        if (dmem_valid) begin
          err_d = 1'b1;
        end
        if (mem_valid) begin
          if (mem_is_load) begin
            pend_wr_en_d = mem_wr_en;
            pend_rd_d    = mem_rd;
            pend_ppp_d   = mem_ppp;
            state_d      = WB_WAIT_LD;
          end else begin
            rf_wr_en_d = rf_commit_ok(mem_wr_en, mem_rd, mem_ppp);
            rf_rd_d    = mem_rd;
            rf_ppp_d   = mem_ppp;
            rf_data_d  = mem_alu_res;
            retired_d  = retired_q + CNT_W'(1);
          end
        end
      end
      WB_WAIT_LD: begin
        if (dmem_valid) begin
          rf_wr_en_d = rf_commit_ok(pend_wr_en_q, pend_rd_q, pend_ppp_q);
          rf_rd_d    = pend_rd_q;
          rf_ppp_d   = pend_ppp_q;
          rf_data_d  = dmem_data;
          retired_d  = retired_q + CNT_W'(1);
          state_d    = WB_IDLE;
        end
      end
      default: state_d = WB_IDLE;
    endcase
    // Stall is registered from the next state so dmem_valid never reaches it combinationally.
    stall_d = (state_d == WB_WAIT_LD);
  end

  // State and output registers; synchronous active-high reset drops any pending load.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= WB_IDLE;
      stall_q      <= 1'b0;
      rf_wr_en_q   <= 1'b0;
      rf_rd_q      <= '0;
      rf_ppp_q     <= '0;
      rf_data_q    <= '0;
      pend_wr_en_q <= 1'b0;
      pend_rd_q    <= '0;
      pend_ppp_q   <= '0;
      retired_q    <= '0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      stall_q      <= stall_d;
      rf_wr_en_q   <= rf_wr_en_d;
      rf_rd_q      <= rf_rd_d;
      rf_ppp_q     <= rf_ppp_d;
      rf_data_q    <= rf_data_d;
      pend_wr_en_q <= pend_wr_en_d;
      pend_rd_q    <= pend_rd_d;
      pend_ppp_q   <= pend_ppp_d;
      retired_q    <= retired_d;
      err_q        <= err_d;
    end
  end

  assign wb_stall      = stall_q;
  assign rf_wr_en      = rf_wr_en_q;
  assign rf_rd         = rf_rd_q;
  assign rf_ppp        = rf_ppp_q;
  assign rf_data       = rf_data_q;
  assign retired       = retired_q;
  assign err_unexp_rsp = err_q;

endmodule
